data_memory_hs: RTL and testbench

//   Parametrised data memory with a valid/ready request/response handshake and configurable access latency.

---
 rtl/data_memory_hs.sv | 136 +++++++++++++
 tb/tb_data_memory_hs.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_hs.sv
// Word-organised data memory with a valid/ready request/response handshake.
// Handles byte/half/word loads and stores and reports illegal accesses as faults.
module data_memory_hs #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     rdata_p1;
    logic            fault_p1;
    logic            accept;
    logic            fault_c;
    logic [AW-1:0]   idx;
    logic [1:0]      off;
    logic [31:0]     rd_word;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] ofs);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return ofs[0];
            2'b10:   return (ofs != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] ofs,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ofs, 3'b000} +: 8];
        h = ofs[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return {{24{b[7] & sgn}}, b};
            2'b01:   return {{16{h[15] & sgn}}, h};
            2'b10:   return word;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] ofs, input logic [1:0] size);
        logic [31:0] res;
        res = old;
        case (size)
            2'b00: res[{ofs, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (ofs[1]) res[31:16] = wd[15:0];
                else        res[15:0]  = wd[15:0];
            end
            2'b10:   res = wd;
            default: res = old;
        endcase
        return res;
    endfunction

    assign idx     = req_addr[AW+1:2];
    assign off     = req_addr[1:0];
    assign rd_word = mem[idx];
    // Range check uses the full word address so high addresses never alias into the array.
    assign fault_c = misaligned(req_size, off) || (req_addr[31:2] >= 30'(DEPTH_WORDS));

    assign rsp_rdata = rdata_p1;
    assign rsp_fault = fault_p1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = (state == IDLE) && !reset;
        rsp_valid = (state == RESP);
        accept    = req_valid && req_ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - CW'(1);
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accept stage: store commits and load data is captured into the response register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rdata_p1 <= '0;
            fault_p1 <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                fault_p1 <= fault_c;
                rdata_p1 <= (fault_c || req_we) ? 32'h0
                                                : load_extract(rd_word, off, req_size, req_signed);
                if (req_we && !fault_c)
                    mem[idx] <= store_merge(rd_word, req_wdata, off, req_size);
            end
        end
    end

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs: one LATENCY=1 instance and one LATENCY=3 instance.
module tb_data_memory_hs;

    logic              clk;
    logic [1:0]        reset;
    logic [1:0]        req_valid, req_ready, req_we, req_signed, rsp_valid, rsp_ready, rsp_fault;
    logic [1:0][31:0]  req_addr, req_wdata, rsp_rdata;
    logic [1:0][1:0]   req_size;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int LAT [2] = '{1, 3};

    data_memory_hs #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_size(req_size[0]), .req_signed(req_signed[0]), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0]));

    data_memory_hs #(.DEPTH_WORDS(64), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_size(req_size[1]), .req_signed(req_signed[1]), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction on instance d; returns the response fields.
    task automatic txn(input int d, input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                       output logic [31:0] rdata, output logic fault);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wdata; req_size[d] = size; req_signed[d] = sgn;
        check({tag, ".ready"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        n = 0;
        while (!rsp_valid[d] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".lat"}, 32'(n), 32'(LAT[d] - 1));
        rdata = rsp_rdata[d];
        fault = rsp_fault[d];
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic expect_rsp(input int d, input string tag, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic sgn,
                              input logic [31:0] exp_data, input logic exp_fault);
        logic [31:0] rd;
        logic        f;
        txn(d, tag, we, addr, wdata, size, sgn, rd, f);
        check({tag, ".rdata"}, rd, exp_data);
        check({tag, ".fault"}, 32'(f), 32'(exp_fault));
    endtask

    initial begin
        logic [31:0] held;
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        reset = 2'b11; req_valid = '0; req_we = '0; req_signed = '0; rsp_ready = '0;
        req_addr = '0; req_wdata = '0; req_size = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.l1.valid", 32'(rsp_valid[0]), 32'd0);
        check("rst.l1.ready", 32'(req_ready[0]), 32'd0);
        check("rst.l3.rdata", rsp_rdata[1], 32'h0);
        @(negedge clk);
        reset = 2'b00;
        #1;
        check("rst.l1.ready_after", 32'(req_ready[0]), 32'd1);

        // Test 1: LW 0x10 with response held off for one extra cycle
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10; req_size[0] = 2'b10;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("t1.valid", 32'(rsp_valid[0]), 32'd1);
        check("t1.rdata", rsp_rdata[0], 32'h0);
        check("t1.fault", 32'(rsp_fault[0]), 32'd0);
        check("t1.ready_busy", 32'(req_ready[0]), 32'd0);
        @(posedge clk); #1;
        check("t1.valid_hold", 32'(rsp_valid[0]), 32'd1);
        check("t1.ready_hold", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        check("t1.valid_drop", 32'(rsp_valid[0]), 32'd0);
        check("t1.ready_back", 32'(req_ready[0]), 32'd1);

        // Test 2: word store, byte overwrite, word load
        expect_rsp(0, "t2.sw", 1, 32'h20, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0);
        expect_rsp(0, "t2.sb", 1, 32'h21, 32'hFFFFFF7F, 2'b00, 0, 32'h0, 0);
        expect_rsp(0, "t2.lw", 0, 32'h20, 32'h0, 2'b10, 0, 32'hDEAD7FEF, 0);
        expect_rsp(0, "t2.lhu", 0, 32'h22, 32'h0, 2'b01, 0, 32'h0000DEAD, 0);

        // Test 3: half store in upper lanes, signed/unsigned loads
        expect_rsp(0, "t3.sh", 1, 32'h42, 32'h12348001, 2'b01, 0, 32'h0, 0);
        expect_rsp(0, "t3.lh", 0, 32'h42, 32'h0, 2'b01, 1, 32'hFFFF8001, 0);
        expect_rsp(0, "t3.lhu", 0, 32'h42, 32'h0, 2'b01, 0, 32'h00008001, 0);
        expect_rsp(0, "t3.lb", 0, 32'h43, 32'h0, 2'b00, 1, 32'hFFFFFF80, 0);
        expect_rsp(0, "t3.lbu", 0, 32'h43, 32'h0, 2'b00, 0, 32'h00000080, 0);
        expect_rsp(0, "t3.lw", 0, 32'h40, 32'h0, 2'b10, 0, 32'h80010000, 0);

        // Test 4: faults return zero data and leave memory untouched
        expect_rsp(0, "t4.lw_mis", 0, 32'h06, 32'h0, 2'b10, 0, 32'h0, 1);
        expect_rsp(0, "t4.sh_mis", 1, 32'h03, 32'hFFFF, 2'b01, 0, 32'h0, 1);
        expect_rsp(0, "t4.size11", 0, 32'h00, 32'h0, 2'b11, 0, 32'h0, 1);
        expect_rsp(0, "t4.sz11_st", 1, 32'h20, 32'h0, 2'b11, 0, 32'h0, 1);
        expect_rsp(0, "t4.lw_oor", 0, 32'h1000, 32'h0, 2'b10, 0, 32'h0, 1);
        expect_rsp(0, "t4.sw_oor", 1, 32'h1000, 32'h12345678, 2'b10, 0, 32'h0, 1);
        expect_rsp(0, "t4.lw0", 0, 32'h00, 32'h0, 2'b10, 0, 32'h0, 0);
        expect_rsp(0, "t4.lw20", 0, 32'h20, 32'h0, 2'b10, 0, 32'hDEAD7FEF, 0);
        expect_rsp(1, "t4.l3_oor", 0, 32'h100, 32'h0, 2'b10, 0, 32'h0, 1);

        // Test 5: LATENCY=3, response back-pressured for 5 cycles
        expect_rsp(1, "t5.sw", 1, 32'h08, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h08; req_size[1] = 2'b10;
        @(posedge clk); #1;
        // Ignored request presented while busy: must not write anything
        req_we[1] = 1'b1; req_wdata[1] = 32'h0; req_addr[1] = 32'h08;
        check("t5.v_t1", 32'(rsp_valid[1]), 32'd0);
        check("t5.r_t1", 32'(req_ready[1]), 32'd0);
        @(posedge clk); #1;
        check("t5.v_t2", 32'(rsp_valid[1]), 32'd0);
        @(posedge clk); #1;
        check("t5.v_t3", 32'(rsp_valid[1]), 32'd1);
        held = rsp_rdata[1];
        check("t5.rdata", held, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5.v_hold", 32'(rsp_valid[1]), 32'd1);
            check("t5.d_hold", rsp_rdata[1], 32'hCAFEF00D);
            check("t5.r_hold", 32'(req_ready[1]), 32'd0);
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        check("t5.v_drop", 32'(rsp_valid[1]), 32'd0);
        expect_rsp(1, "t5.lw_again", 0, 32'h08, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0);

        // Test 6: reset in WAIT and while a store is presented
        expect_rsp(1, "t6.sw", 1, 32'h04, 32'h11111111, 2'b10, 0, 32'h0, 0);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h04; req_size[1] = 2'b10;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        reset[1] = 1'b1;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h0C; req_wdata[1] = 32'h55555555;
        @(posedge clk); #1;
        check("t6.v_rst", 32'(rsp_valid[1]), 32'd0);
        check("t6.r_rst", 32'(req_ready[1]), 32'd0);
        @(posedge clk); #1;
        check("t6.v_rst2", 32'(rsp_valid[1]), 32'd0);
        @(negedge clk);
        reset[1] = 1'b0;
        req_valid[1] = 1'b0;
        #1;
        check("t6.idle", 32'(req_ready[1]), 32'd1);
        check("t6.rdata_clr", rsp_rdata[1], 32'h0);
        expect_rsp(1, "t6.lw_c", 0, 32'h0C, 32'h0, 2'b10, 0, 32'h0, 0);
        expect_rsp(1, "t6.lw_4", 0, 32'h04, 32'h0, 2'b10, 0, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
